// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon memory-sequence game controller.
package simon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    SHOW_ON,
    SHOW_OFF,
    WAIT_IN,
    WIN,
    LOSE
  } state_e;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // Index width for a table of n entries; a single entry still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/simon_lfsr16.sv
// 16-bit Galois LFSR (taps 16,14,13,11); a non-zero seed keeps it out of the all-zero lock-up state.
module simon_lfsr16
  import simon_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] state
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    state_d = state_q;
    if (en) begin
      state_d = state_q[0] ? ((state_q >> 1) ^ LFSR_MASK) : (state_q >> 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/simon_game_ctrl.sv
// Simon game controller: grows a random sequence, plays it on the LEDs and
// checks the player's button presses with a per-press timeout.
module simon_game_ctrl
  import simon_pkg::*;
#(
  parameter int          N_CH      = 4,
  parameter int          MAX_LEN   = 16,
  parameter int          TICKS_ON  = 50000000,
  parameter int          TICKS_OFF = 12500000,
  parameter int          TIMEOUT   = 250000000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                         osc_clk,
  input  logic                         reset_n,
  input  logic [N_CH-1:0]              button,
  input  logic                         start,
  output logic [N_CH-1:0]              led,
  output logic [$clog2(MAX_LEN+1)-1:0] level,
  output logic                         busy,
  output logic                         win,
  output logic                         game_over
);

  localparam int IDX_W    = idx_w(N_CH);
  localparam int LVL_W    = $clog2(MAX_LEN + 1);
  localparam int ADDR_W   = idx_w(MAX_LEN);
  localparam int SHOW_MAX = (TICKS_ON > TICKS_OFF) ? TICKS_ON : TICKS_OFF;
  localparam int CNT_MAX  = (SHOW_MAX > TIMEOUT) ? SHOW_MAX : TIMEOUT;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(TICKS_ON - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(TICKS_OFF - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(MAX_LEN);
  localparam logic [N_CH-1:0]  OH_LSB   = N_CH'(1);

  state_e             state_q, state_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [LVL_W-1:0]   pos_q, pos_d;
  logic [CNT_W-1:0]   tmr_q, tmr_d;
  logic               phase_q, phase_d;
  logic [N_CH-1:0]    button_q;
  logic [N_CH-1:0]    press_q, press_d;

  logic [IDX_W-1:0]   pat_mem_q [MAX_LEN];
  logic               pat_we;
  logic [IDX_W-1:0]   pat_wdata;
  logic [15:0]        lfsr;
  logic [15:0]        lfsr_mod;
  logic [N_CH-1:0]    cur_oh;
  logic               last_step;

  simon_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (osc_clk),
    .rst_n (reset_n),
    .en    (1'b1),
    .state (lfsr)
  );

  // Only the low byte of the LFSR picks the next colour.
  assign lfsr_mod  = (lfsr & 16'h00FF) % 16'(N_CH);
  assign pat_wdata = IDX_W'(lfsr_mod);
  assign cur_oh    = OH_LSB << pat_mem_q[pos_q[ADDR_W-1:0]];
  assign last_step = (pos_q == (level_q - LVL_W'(1)));
  assign press_d   = button & ~button_q;

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    pos_d   = pos_q;
    tmr_d   = tmr_q;
    phase_d = phase_q;
    pat_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = GEN;
          level_d = '0;
        end
      end
      GEN: begin
        pat_we  = 1'b1;
        level_d = level_q + LVL_W'(1);
        pos_d   = '0;
        tmr_d   = '0;
        state_d = SHOW_ON;
      end
      SHOW_ON: begin
        if (tmr_q == ON_LAST) begin
          tmr_d   = '0;
          state_d = SHOW_OFF;
        end else begin
          tmr_d = tmr_q + CNT_W'(1);
        end
      end
      SHOW_OFF: begin
        if (tmr_q == OFF_LAST) begin
          tmr_d = '0;
          if (last_step) begin
            pos_d   = '0;
            state_d = WAIT_IN;
          end else begin
            pos_d   = pos_q + LVL_W'(1);
            state_d = SHOW_ON;
          end
        end else begin
          tmr_d = tmr_q + CNT_W'(1);
        end
      end
      WAIT_IN: begin
        // A press always wins over a timeout expiring in the same cycle.
        if (press_q != '0) begin
          tmr_d = '0;
          if (press_q != cur_oh) begin
            state_d = LOSE;
          end else if (!last_step) begin
            pos_d = pos_q + LVL_W'(1);
          end else if (level_q == LVL_MAX) begin
            phase_d = 1'b1;
            state_d = WIN;
          end else begin
            state_d = GEN;
          end
        end else if (tmr_q == TO_LAST) begin
          state_d = LOSE;
        end else begin
          tmr_d = tmr_q + CNT_W'(1);
        end
      end
      WIN: begin
        if (start) begin
          state_d = GEN;
          level_d = '0;
        end else if (tmr_q == ON_LAST) begin
          tmr_d   = '0;
          phase_d = ~phase_q;
        end else begin
          tmr_d = tmr_q + CNT_W'(1);
        end
      end
      LOSE: begin
        if (start) begin
          state_d = GEN;
          level_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge osc_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      level_q  <= '0;
      pos_q    <= '0;
      tmr_q    <= '0;
      phase_q  <= 1'b0;
      button_q <= '0;
      press_q  <= '0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      pos_q    <= pos_d;
      tmr_q    <= tmr_d;
      phase_q  <= phase_d;
      button_q <= button;
      press_q  <= press_d;
    end
  end

  // Sequence storage holds data only, so it carries no reset.
  always_ff @(posedge osc_clk) begin
    if (pat_we) begin
      pat_mem_q[level_q[ADDR_W-1:0]] <= pat_wdata;
    end
  end

  always_comb begin
    led = '0;
    case (state_q)
      SHOW_ON: led = cur_oh;
      WAIT_IN: led = button;
      WIN:     led = phase_q ? '1 : '0;
      default: led = '0;
    endcase
  end

  assign level     = level_q;
  assign busy      = !((state_q == IDLE) || (state_q == WIN) || (state_q == LOSE));
  assign win       = (state_q == WIN);
  assign game_over = (state_q == LOSE);

endmodule

// File: tb/tb_simon_game_ctrl.sv
// Directed bench for simon_game_ctrl with short timing parameters and a reference LFSR.
module tb_simon_game_ctrl;

  logic       osc_clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] button  = 4'h0;
  logic       start   = 1'b0;
  logic [3:0] led;
  logic [1:0] level;
  logic       busy;
  logic       win;
  logic       game_over;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_lfsr;
  int          m_pat [3];
  int          m_level = 0;

  simon_game_ctrl #(
    .N_CH      (4),
    .MAX_LEN   (3),
    .TICKS_ON  (4),
    .TICKS_OFF (2),
    .TIMEOUT   (20),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .osc_clk   (osc_clk),
    .reset_n   (reset_n),
    .button    (button),
    .start     (start),
    .led       (led),
    .level     (level),
    .busy      (busy),
    .win       (win),
    .game_over (game_over)
  );

  always #5 osc_clk = ~osc_clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic logic [3:0] oh(input int i);
    logic [3:0] r;
    r = 4'b0001 << i;
    return r;
  endfunction

  always @(posedge osc_clk or negedge reset_n) begin
    if (!reset_n) m_lfsr <= 16'hACE1;
    else          m_lfsr <= lfsr_next(m_lfsr);
  end

  task automatic step(input int n);
    repeat (n) @(negedge osc_clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start   = 1'b0;
    m_level = 0;
  endtask

  // Called on the GEN cycle; returns on the first WAIT_IN cycle.
  task automatic gen_show();
    m_pat[m_level] = int'(m_lfsr[7:0]) % 4;
    m_level++;
    step(1 + 6 * m_level);
  endtask

  task automatic press(input logic [3:0] b);
    button = b;
    step(1);
    button = 4'h0;
    step(1);
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    step(3);
    reset_n = 1'b1;
    step(10);
    checks++; if (led !== 4'h0) begin errors++; $display("FAIL reset_led: got %h expected %h", led, 4'h0); end
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL reset_level: got %0d expected %0d", level, 0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected %b", busy, 1'b0); end
    checks++; if (win !== 1'b0) begin errors++; $display("FAIL reset_win: got %b expected %b", win, 1'b0); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over: got %b expected %b", game_over, 1'b0); end
    checks++; if (dut.u_lfsr.state_q !== m_lfsr) begin errors++; $display("FAIL reset_lfsr: got %h expected %h", dut.u_lfsr.state_q, m_lfsr); end
  endtask

  task automatic test_playback();
    pulse_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gen_busy: got %b expected %b", busy, 1'b1); end
    checks++; if (led !== 4'h0) begin errors++; $display("FAIL gen_led: got %h expected %h", led, 4'h0); end
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL gen_level: got %0d expected %0d", level, 0); end
    m_pat[0] = int'(m_lfsr[7:0]) % 4;
    m_level  = 1;
    for (int c = 0; c < 4; c++) begin
      step(1);
      start = (c == 0);
      checks++; if (led !== oh(m_pat[0])) begin errors++; $display("FAIL show_on_c%0d: got %h expected %h", c, led, oh(m_pat[0])); end
    end
    start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step(1);
      checks++; if (led !== 4'h0) begin errors++; $display("FAIL show_off_c%0d: got %h expected %h", c, led, 4'h0); end
    end
    step(1);
    checks++; if (level !== 2'd1) begin errors++; $display("FAIL wait_level: got %0d expected %0d", level, 1); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wait_busy: got %b expected %b", busy, 1'b1); end
  endtask

  task automatic test_full_game();
    logic [3:0] exp_led;
    button = oh(m_pat[0]);
    #1;
    checks++; if (led !== oh(m_pat[0])) begin errors++; $display("FAIL wait_echo: got %h expected %h", led, oh(m_pat[0])); end
    step(1);
    button = 4'h0;
    step(1);
    checks++; if (busy !== 1'b1 || level !== 2'd1) begin errors++; $display("FAIL r2_gen: got busy=%b level=%0d expected busy=1 level=1", busy, level); end
    m_pat[1] = int'(m_lfsr[7:0]) % 4;
    m_level  = 2;
    for (int j = 0; j < 2; j++) begin
      for (int c = 0; c < 4; c++) begin
        step(1);
        checks++; if (led !== oh(m_pat[j])) begin errors++; $display("FAIL r2_step%0d_on: got %h expected %h", j, led, oh(m_pat[j])); end
      end
      for (int c = 0; c < 2; c++) begin
        step(1);
        checks++; if (led !== 4'h0) begin errors++; $display("FAIL r2_step%0d_off: got %h expected %h", j, led, 4'h0); end
      end
    end
    step(1);
    checks++; if (level !== 2'd2) begin errors++; $display("FAIL r2_level: got %0d expected %0d", level, 2); end
    press(oh(m_pat[0]));
    press(oh(m_pat[1]));
    gen_show();
    checks++; if (level !== 2'd3) begin errors++; $display("FAIL r3_level: got %0d expected %0d", level, 3); end
    press(oh(m_pat[0]));
    press(oh(m_pat[1]));
    checks++; if (game_over !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL r3_mid: got game_over=%b busy=%b expected 0 1", game_over, busy); end
    press(oh(m_pat[2]));
    checks++; if (win !== 1'b1) begin errors++; $display("FAIL win_flag: got %b expected %b", win, 1'b1); end
    checks++; if (busy !== 1'b0 || game_over !== 1'b0) begin errors++; $display("FAIL win_status: got busy=%b game_over=%b expected 0 0", busy, game_over); end
    checks++; if (level !== 2'd3) begin errors++; $display("FAIL win_level: got %0d expected %0d", level, 3); end
    for (int i = 0; i < 12; i++) begin
      exp_led = (((i / 4) % 2) == 0) ? 4'hF : 4'h0;
      checks++; if (led !== exp_led) begin errors++; $display("FAIL win_led_c%0d: got %h expected %h", i, led, exp_led); end
      step(1);
    end
  endtask

  task automatic test_wrong_press();
    pulse_start();
    checks++; if (win !== 1'b0 || level !== 2'd0 || busy !== 1'b1) begin errors++; $display("FAIL restart_from_win: got win=%b level=%0d busy=%b expected 0 0 1", win, level, busy); end
    gen_show();
    press(oh(m_pat[0]));
    gen_show();
    press(oh((m_pat[0] + 1) % 4));
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL wrong_game_over: got %b expected %b", game_over, 1'b1); end
    checks++; if (led !== 4'h0) begin errors++; $display("FAIL wrong_led: got %h expected %h", led, 4'h0); end
    checks++; if (level !== 2'd2) begin errors++; $display("FAIL wrong_level: got %0d expected %0d", level, 2); end
    checks++; if (busy !== 1'b0 || win !== 1'b0) begin errors++; $display("FAIL wrong_status: got busy=%b win=%b expected 0 0", busy, win); end
    step(3);
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL lose_hold: got %b expected %b", game_over, 1'b1); end
    pulse_start();
    checks++; if (game_over !== 1'b0 || level !== 2'd0) begin errors++; $display("FAIL restart_from_lose: got game_over=%b level=%0d expected 0 0", game_over, level); end
    gen_show();
    checks++; if (level !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL restart_level: got level=%0d busy=%b expected 1 1", level, busy); end
  endtask

  task automatic test_timeout();
    step(19);
    checks++; if (game_over !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL timeout_early: got game_over=%b busy=%b expected 0 1", game_over, busy); end
    step(1);
    checks++; if (game_over !== 1'b1 || level !== 2'd1) begin errors++; $display("FAIL timeout_lose: got game_over=%b level=%0d expected 1 1", game_over, level); end
    pulse_start();
    gen_show();
    press(oh(m_pat[0]));
    gen_show();
    step(18);
    button = oh(m_pat[0]);
    step(1);
    button = 4'h0;
    step(1);
    checks++; if (game_over !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL press_at_expiry: got game_over=%b busy=%b expected 0 1", game_over, busy); end
    step(19);
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL timer_restart: got %b expected %b", game_over, 1'b0); end
    step(1);
    checks++; if (game_over !== 1'b1 || level !== 2'd2) begin errors++; $display("FAIL timeout_r2: got game_over=%b level=%0d expected 1 2", game_over, level); end
  endtask

  task automatic test_two_buttons();
    pulse_start();
    gen_show();
    press(oh(m_pat[0]) | oh((m_pat[0] + 1) % 4));
    checks++; if (game_over !== 1'b1 || level !== 2'd1) begin errors++; $display("FAIL two_buttons: got game_over=%b level=%0d expected 1 1", game_over, level); end
  endtask

  task automatic test_async_reset();
    pulse_start();
    m_pat[0] = int'(m_lfsr[7:0]) % 4;
    m_level  = 1;
    step(2);
    checks++; if (led !== oh(m_pat[0])) begin errors++; $display("FAIL pre_reset_led: got %h expected %h", led, oh(m_pat[0])); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (led !== 4'h0) begin errors++; $display("FAIL async_reset_led: got %h expected %h", led, 4'h0); end
    checks++; if (busy !== 1'b0 || level !== 2'd0) begin errors++; $display("FAIL async_reset_state: got busy=%b level=%0d expected 0 0", busy, level); end
    checks++; if (win !== 1'b0 || game_over !== 1'b0) begin errors++; $display("FAIL async_reset_flags: got win=%b game_over=%b expected 0 0", win, game_over); end
    @(negedge osc_clk);
    reset_n = 1'b1;
    step(5);
    checks++; if (dut.u_lfsr.state_q !== m_lfsr) begin errors++; $display("FAIL post_reset_lfsr: got %h expected %h", dut.u_lfsr.state_q, m_lfsr); end
    checks++; if (busy !== 1'b0 || led !== 4'h0) begin errors++; $display("FAIL post_reset_idle: got busy=%b led=%h expected 0 0", busy, led); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_playback();
    test_full_game();
    test_wrong_press();
    test_timeout();
    test_two_buttons();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
